branch_pc_ctrl: RTL

//  Owns the fetch PC. Sequences branch/jump resolution from EX through a branch compare sub-module.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_pc_ctrl_br_cmp.sv | 32 +++
 rtl/branch_pc_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch/PC controller.
package branch_pkg;

    typedef enum logic [3:0] {
        BEQ  = 4'b1000,
        BNE  = 4'b1001,
        BLT  = 4'b1100,
        BGE  = 4'b1101,
        JAL  = 4'b0010,
        JALR = 4'b0011
    } br_op_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } ctrl_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/branch_pc_ctrl_br_cmp.sv
// Combinational branch condition evaluator: signed compare of two operands by opcode.
module br_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic            taken_o
);

    logic eq;
    logic lt;

    assign eq = (a_i == b_i);
    assign lt = ($signed(a_i) < $signed(b_i));

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BEQ:     taken_o = eq;
            BNE:     taken_o = !eq;
            BLT:     taken_o = lt;
            BGE:     taken_o = !lt;
            JAL:     taken_o = 1'b1;
            JALR:    taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch PC owner: resolves EX branches, redirects fetch and squashes wrong-path fetches.
// Build option MISALIGN_TRAP_EN: misaligned taken targets trap instead of being aligned.
module branch_pc_ctrl
    import branch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            br_valid_i,
    input  logic [3:0]      br_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            taken_o,
    output logic            redirect_o,
    output logic            flush_o,
    output logic            trap_o,
    output ctrl_state_t     dbg_state_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] NOT_BIT0 = ~XLEN'(1);
    localparam logic [XLEN-1:0] NOT_LOW2 = ~XLEN'(3);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             redirect_q, redirect_d;
    logic             flush_q, flush_d;

    logic             cmp_taken;
    logic             accept;
    logic             take;
    logic [XLEN-1:0]  raw_target;
    logic [XLEN-1:0]  target;

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .a_i     (rs1_i),
        .b_i     (rs2_i),
        .op_i    (br_op_i),
        .taken_o (cmp_taken)
    );

    assign link_o = br_pc_i + STEP;

    // br_valid_i has no ready: it is consumed only in RUN; in FLUSH/TRAP it is wrong-path and dropped.
    assign accept = (state_q == RUN) && br_valid_i;
    assign take   = accept && cmp_taken;

    assign raw_target = (br_op_i == JALR) ? ((rs1_i + imm_i) & NOT_BIT0)
                                          : (br_pc_i + imm_i);

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic misalign;

    assign target   = raw_target;
    assign misalign = (raw_target[1:0] != 2'b00);
`else
    assign target   = raw_target & NOT_LOW2;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        taken_d    = 1'b0;
        redirect_d = 1'b0;
        flush_d    = flush_q;
`ifdef MISALIGN_TRAP_EN
        trap_d     = trap_q;
`endif
        case (state_q)
            RUN: begin
                flush_d = 1'b0;
                taken_d = take;
                if (take) begin
`ifdef MISALIGN_TRAP_EN
                    if (misalign) begin
                        state_d = TRAP;
                        trap_d  = 1'b1;
                        flush_d = 1'b1;
                    end else
`endif
                    begin
                        // A taken branch wins over stall_i: the target must load now.
                        pc_d       = target;
                        redirect_d = 1'b1;
                        flush_d    = 1'b1;
                        cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
                        state_d    = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_q + STEP;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                if (!stall_i) begin
                    pc_d = pc_q + STEP;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
`ifdef MISALIGN_TRAP_EN
            TRAP: begin
                flush_d = 1'b1;
                trap_d  = 1'b1;
            end
`endif
            default: begin
                state_d = RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap_o = trap_q;
`else
    assign trap_o = 1'b0;
`endif

    assign pc_o        = pc_q;
    assign taken_o     = taken_q;
    assign redirect_o  = redirect_q;
    assign flush_o     = flush_q;
    assign dbg_state_o = state_q;

endmodule
